// File: rtl/poly_mv_mult_scheduler.sv
// Walks the shared polynomial multiplier through every A[i][j]*s[j] product of one
// matrix-vector job, driving base addresses, overwrite/accumulate and the start/done handshake.
module poly_mv_mult_scheduler #(
   parameter int ADDR_W     = 12,
   parameter int POLY_WORDS = 64,
   parameter int MAX_RANK   = 4,
   parameter int A_BASE     = 0,
   parameter int S_BASE     = 1024,
   parameter int R_BASE     = 1280,
   parameter int TIMEOUT    = 16383
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [2:0]        rank_i,
   input  logic              transpose_i,
   input  logic              abort_i,
   input  logic              mult_done_i,
   output logic              mult_start_o,
   output logic              mult_acc_o,
   output logic [ADDR_W-1:0] a_base_o,
   output logic [ADDR_W-1:0] s_base_o,
   output logic [ADDR_W-1:0] res_base_o,
   output logic [1:0]        row_idx_o,
   output logic [1:0]        col_idx_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 14) ? $clog2(TIMEOUT + 1) : 14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_NEXT,
      ST_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        i_q, i_d;
   logic [1:0]        j_q, j_d;
   logic [2:0]        rank_q, rank_d;
   logic              trans_q, trans_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              error_q, error_d;

   logic              mult_start_q;
   logic              mult_acc_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] a_base_q, s_base_q, res_base_q;
   logic [1:0]        row_q, col_q;

   logic              rank_ok;
   logic              last_prod;
   logic [1:0]        rank_m1;
   logic              issue_d;
   logic [ADDR_W-1:0] idx_d, a_base_d, s_base_d, res_base_d;

   assign rank_ok   = (rank_i >= 3'd2) && (rank_i <= 3'(MAX_RANK));
   assign rank_m1   = 2'(rank_q - 3'd1);
   assign last_prod = (i_q == rank_m1) && (j_q == rank_m1);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      rank_d  = rank_q;
      trans_d = trans_q;
      error_d = error_q;
      cnt_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (rank_ok) begin
                  state_d = ST_ISSUE;
                  i_d     = 2'd0;
                  j_d     = 2'd0;
                  rank_d  = rank_i;
                  trans_d = transpose_i;
                  error_d = 1'b0;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (mult_done_i) begin
               state_d = ST_NEXT;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_NEXT: begin
            if (j_q != rank_m1) begin
               j_d = j_q + 2'd1;
            end else begin
               j_d = 2'd0;
               i_d = i_q + 2'd1;
            end
            state_d = last_prod ? ST_FINISH : ST_ISSUE;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // Abort outranks both completion and timeout and leaves the error flag alone.
      if (abort_i && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         error_d = error_q;
      end
   end

   // Operand/result addresses are computed for the product about to be issued so they
   // are registered alongside mult_start.
   assign issue_d    = (state_d == ST_ISSUE);
   assign idx_d      = trans_d ? (ADDR_W'(j_d) * ADDR_W'(rank_d) + ADDR_W'(i_d))
                               : (ADDR_W'(i_d) * ADDR_W'(rank_d) + ADDR_W'(j_d));
   assign a_base_d   = ADDR_W'(A_BASE) + idx_d * ADDR_W'(POLY_WORDS);
   assign s_base_d   = ADDR_W'(S_BASE) + ADDR_W'(j_d) * ADDR_W'(POLY_WORDS);
   assign res_base_d = ADDR_W'(R_BASE) + ADDR_W'(i_d) * ADDR_W'(POLY_WORDS);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         i_q          <= '0;
         j_q          <= '0;
         rank_q       <= '0;
         trans_q      <= 1'b0;
         cnt_q        <= '0;
         error_q      <= 1'b0;
         mult_start_q <= 1'b0;
         mult_acc_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         a_base_q     <= '0;
         s_base_q     <= '0;
         res_base_q   <= '0;
         row_q        <= '0;
         col_q        <= '0;
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         j_q          <= j_d;
         rank_q       <= rank_d;
         trans_q      <= trans_d;
         cnt_q        <= cnt_d;
         error_q      <= error_d;
         mult_start_q <= issue_d;
         busy_q       <= (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_NEXT);
         done_q       <= (state_d == ST_FINISH);
         if (issue_d) begin
            a_base_q   <= a_base_d;
            s_base_q   <= s_base_d;
            res_base_q <= res_base_d;
            mult_acc_q <= (j_d != 2'd0);
            row_q      <= i_d;
            col_q      <= j_d;
         end
      end
   end

   // A same-cycle abort must suppress a start or done pulse that is already registered.
   assign mult_start_o = mult_start_q & ~abort_i;
   assign done_o       = done_q & ~abort_i;
   assign mult_acc_o   = mult_acc_q;
   assign a_base_o     = a_base_q;
   assign s_base_o     = s_base_q;
   assign res_base_o   = res_base_q;
   assign row_idx_o    = row_q;
   assign col_idx_o    = col_q;
   assign busy_o       = busy_q;
   assign error_o      = error_q;

endmodule

// File: tb/tb_poly_mv_mult_scheduler.sv
// Self-checking bench: table of jobs, hand-written corner sequences and random jobs,
// each compared against a product-list model built directly from the matrix-vector rules.
module tb_poly_mv_mult_scheduler;

   localparam int ADDR_W     = 12;
   localparam int POLY_WORDS = 64;
   localparam int MAX_RANK   = 4;
   localparam int A_BASE     = 0;
   localparam int S_BASE     = 1024;
   localparam int R_BASE     = 1280;
   localparam int TIMEOUT    = 16383;
   localparam int BUDGET     = TIMEOUT + 1000;

   logic              clk = 1'b0;
   logic              reset_i = 1'b0;
   logic              start_i = 1'b0;
   logic [2:0]        rank_i = 3'd0;
   logic              transpose_i = 1'b0;
   logic              abort_i = 1'b0;
   logic              mult_done_i = 1'b0;
   logic              mult_start_o;
   logic              mult_acc_o;
   logic [ADDR_W-1:0] a_base_o;
   logic [ADDR_W-1:0] s_base_o;
   logic [ADDR_W-1:0] res_base_o;
   logic [1:0]        row_idx_o;
   logic [1:0]        col_idx_o;
   logic              busy_o;
   logic              done_o;
   logic              error_o;

   always #5 clk = ~clk;

   poly_mv_mult_scheduler #(
      .ADDR_W(ADDR_W), .POLY_WORDS(POLY_WORDS), .MAX_RANK(MAX_RANK), .A_BASE(A_BASE),
      .S_BASE(S_BASE), .R_BASE(R_BASE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .rank_i(rank_i),
      .transpose_i(transpose_i), .abort_i(abort_i), .mult_done_i(mult_done_i),
      .mult_start_o(mult_start_o), .mult_acc_o(mult_acc_o), .a_base_o(a_base_o),
      .s_base_o(s_base_o), .res_base_o(res_base_o), .row_idx_o(row_idx_o),
      .col_idx_o(col_idx_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   typedef struct {
      int cyc;
      int row;
      int col;
      int acc;
      int a;
      int s;
      int r;
   } pulse_t;

   typedef struct {
      int rank;
      int trans;
      int delay;
      int exp_pulses;
      int exp_err;
   } job_t;

   pulse_t pulses[$];
   int cyc = 0;
   int done_cnt = 0;
   int done_busy_bad = 0;
   int busy_seen = 0;
   int resp_delay = 1;
   int resp_limit = 0;
   int resp_cnt = 0;
   int err_prev = 0;
   int err_cyc = -1;
   int err_busy = 0;
   int start_cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   // Monitor plus multiplier stand-in: samples on the falling edge, answers each
   // mult_start with a one-cycle mult_done resp_delay cycles later.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (mult_start_o)
            pulses.push_back('{cyc, int'(row_idx_o), int'(col_idx_o), int'(mult_acc_o),
                               int'(a_base_o), int'(s_base_o), int'(res_base_o)});
         if (busy_o) busy_seen = 1;
         if (done_o) begin
            done_cnt++;
            if (busy_o) done_busy_bad++;
         end
         if (error_o && (err_prev == 0)) begin
            err_cyc  = cyc;
            err_busy = int'(busy_o);
         end
         err_prev = int'(error_o);
         mult_done_i = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) mult_done_i = 1'b1;
         end
         if (mult_start_o && ((resp_limit == 0) || (pulses.size() < resp_limit)))
            resp_cnt = resp_delay;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
      $fatal(1, "watchdog");
   end

   function automatic pulse_t model(input int rk, input int tr, input int i, input int j);
      pulse_t p;
      int idx;
      int m;
      m     = 1 << ADDR_W;
      idx   = (tr != 0) ? (j * rk + i) : (i * rk + j);
      p.cyc = 0;
      p.row = i;
      p.col = j;
      p.acc = (j != 0) ? 1 : 0;
      p.a   = (A_BASE + idx * POLY_WORDS) % m;
      p.s   = (S_BASE + j * POLY_WORDS) % m;
      p.r   = (R_BASE + i * POLY_WORDS) % m;
      return p;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_pulse(input string name, input pulse_t got, input pulse_t exp);
      n_checks++;
      if (got.row != exp.row || got.col != exp.col || got.acc != exp.acc ||
          got.a != exp.a || got.s != exp.s || got.r != exp.r) begin
         n_fail++;
         $display("FAIL %s: got i=%0d j=%0d acc=%0d a=%0d s=%0d r=%0d expected i=%0d j=%0d acc=%0d a=%0d s=%0d r=%0d",
                  name, got.row, got.col, got.acc, got.a, got.s, got.r,
                  exp.row, exp.col, exp.acc, exp.a, exp.s, exp.r);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic begin_job(input int dly, input int limit);
      pulses.delete();
      done_cnt      = 0;
      done_busy_bad = 0;
      busy_seen     = 0;
      resp_delay    = dly;
      resp_limit    = limit;
      err_cyc       = -1;
   endtask

   task automatic pulse_job(input int rk, input int tr);
      step();
      start_i     = 1'b1;
      rank_i      = 3'(rk);
      transpose_i = 1'(tr);
      start_cyc   = cyc;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_job();
      int n;
      n = 0;
      while (!((done_cnt > 0) || ((n >= 4) && !busy_o)) && (n < BUDGET)) begin
         step();
         n++;
      end
      chk("job_finished_in_budget", (n < BUDGET) ? 1 : 0, 1);
      repeat (2) step();
   endtask

   task automatic check_job(input int rk, input int tr, input int dly,
                            input int exp_pulses, input int exp_err);
      chk("pulse_count", pulses.size(), exp_pulses);
      chk("done_count", done_cnt, (exp_pulses > 0) ? 1 : 0);
      chk("busy_low_in_done_cycle", done_busy_bad, 0);
      chk("busy_seen", busy_seen, (exp_pulses > 0) ? 1 : 0);
      chk("error_after_job", int'(error_o), exp_err);
      if ((exp_pulses > 0) && (pulses.size() == exp_pulses)) begin
         chk("first_start_latency", pulses[0].cyc - start_cyc, 1);
         for (int k = 0; k < exp_pulses; k++) begin
            chk_pulse("product", pulses[k], model(rk, tr, k / rk, k % rk));
            if (k > 0) chk("done_to_start_gap", pulses[k].cyc - pulses[k-1].cyc, dly + 2);
         end
      end
      $display("job rank=%0d transpose=%0d delay=%0d pulses=%0d done=%0d error=%0d",
               rk, tr, dly, pulses.size(), done_cnt, error_o);
   endtask

   initial begin
      job_t   jobs[9];
      pulse_t r2_exp[4];
      int     n;

      jobs[0] = '{2, 0, 5, 4, 0};
      jobs[1] = '{3, 1, 3, 9, 0};
      jobs[2] = '{1, 0, 3, 0, 1};
      jobs[3] = '{5, 0, 3, 0, 1};
      jobs[4] = '{2, 1, 2, 4, 0};
      jobs[5] = '{4, 0, 1, 16, 0};
      jobs[6] = '{0, 1, 2, 0, 1};
      jobs[7] = '{7, 0, 2, 0, 1};
      jobs[8] = '{4, 1, 4, 16, 0};
      r2_exp[0] = '{0, 0, 0, 0, 0,   1024, 1280};
      r2_exp[1] = '{0, 0, 1, 1, 64,  1088, 1280};
      r2_exp[2] = '{0, 1, 0, 0, 128, 1024, 1344};
      r2_exp[3] = '{0, 1, 1, 1, 192, 1088, 1344};

      #1 reset_i = 1'b1;
      #2;
      chk("reset_outputs", longint'({mult_start_o, mult_acc_o, a_base_o, s_base_o, res_base_o,
                                     row_idx_o, col_idx_o, busy_o, done_o, error_o}), 0);
      repeat (2) @(negedge clk);
      #1 reset_i = 1'b0;

      for (int t = 0; t < 9; t++) begin
         begin_job(jobs[t].delay, 0);
         pulse_job(jobs[t].rank, jobs[t].trans);
         wait_job();
         check_job(jobs[t].rank, jobs[t].trans, jobs[t].delay, jobs[t].exp_pulses, jobs[t].exp_err);
         if ((t == 0) && (pulses.size() == 4))
            for (int k = 0; k < 4; k++) chk_pulse("rank2_plan", pulses[k], r2_exp[k]);
         if ((t == 1) && (pulses.size() == 9)) begin
            chk("rank3_t_pulse2_a_base", pulses[1].a, 192);
            chk("rank3_t_pulse6_a_base", pulses[5].a, 448);
            chk("rank3_t_last_res_base", pulses[8].r, 1408);
         end
      end

      // mult_done withheld after the third product of a rank-4 job
      begin_job(2, 3);
      pulse_job(4, 0);
      n = 0;
      while (!error_o && (n < BUDGET)) begin
         step();
         n++;
      end
      chk("timeout_in_budget", (n < BUDGET) ? 1 : 0, 1);
      repeat (2) step();
      chk("timeout_pulses", pulses.size(), 3);
      chk("timeout_done", done_cnt, 0);
      chk("timeout_error", int'(error_o), 1);
      chk("timeout_busy_at_error", err_busy, 0);
      chk("timeout_busy_after", int'(busy_o), 0);
      if (pulses.size() == 3) chk("timeout_latency", err_cyc - pulses[2].cyc, TIMEOUT + 1);
      $display("timeout job rank=4 pulses=%0d error=%0d error_cycle=%0d", pulses.size(), error_o, err_cyc);

      // abort coincident with mult_done in the second WAIT; stray starts while busy
      begin_job(5, 0);
      pulse_job(3, 0);
      n = 0;
      while ((pulses.size() < 1) && (n < BUDGET)) begin
         step();
         n++;
      end
      start_i     = 1'b1;
      rank_i      = 3'd4;
      transpose_i = 1'b1;
      step();
      start_i = 1'b0;
      n = 0;
      while (!((pulses.size() == 2) && mult_done_i) && (n < BUDGET)) begin
         step();
         n++;
      end
      chk("abort_point_reached", (n < BUDGET) ? 1 : 0, 1);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("abort_busy_next_cycle", int'(busy_o), 0);
      repeat (20) step();
      chk("abort_pulses", pulses.size(), 2);
      chk("abort_done", done_cnt, 0);
      chk("abort_error", int'(error_o), 0);
      if (pulses.size() >= 2) begin
         chk_pulse("abort_product0", pulses[0], model(3, 0, 0, 0));
         chk_pulse("abort_product1", pulses[1], model(3, 0, 0, 1));
      end
      $display("abort job rank=3 pulses=%0d done=%0d error=%0d", pulses.size(), done_cnt, error_o);

      // abort during the ISSUE cycle suppresses the start pulse itself
      begin_job(3, 0);
      step();
      start_i     = 1'b1;
      rank_i      = 3'd2;
      transpose_i = 1'b0;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      abort_i = 1'b1;
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      repeat (10) step();
      chk("abort_issue_pulses", pulses.size(), 0);
      chk("abort_issue_done", done_cnt, 0);
      chk("abort_issue_busy", int'(busy_o), 0);
      $display("abort-in-issue job rank=2 pulses=%0d busy=%0d", pulses.size(), busy_o);

      // asynchronous reset in the middle of a WAIT
      begin_job(10, 0);
      pulse_job(4, 0);
      n = 0;
      while ((pulses.size() < 2) && (n < BUDGET)) begin
         step();
         n++;
      end
      repeat (3) step();
      chk("pre_reset_busy", int'(busy_o), 1);
      #2 reset_i = 1'b1;
      #1;
      chk("reset_async_outputs", longint'({mult_start_o, mult_acc_o, a_base_o, s_base_o, res_base_o,
                                           row_idx_o, col_idx_o, busy_o, done_o, error_o}), 0);
      @(negedge clk);
      #1 reset_i = 1'b0;
      repeat (15) step();
      chk("reset_idle_pulses", pulses.size(), 2);
      chk("reset_idle_busy", int'(busy_o), 0);
      $display("reset mid-wait pulses=%0d busy=%0d", pulses.size(), busy_o);
      begin_job(3, 0);
      pulse_job(2, 0);
      wait_job();
      check_job(2, 0, 3, 4, 0);

      for (int t = 0; t < 6; t++) begin
         int rk;
         int tr;
         int dly;
         int legal;
         rk    = int'($urandom_range(0, 7));
         tr    = int'($urandom_range(0, 1));
         dly   = int'($urandom_range(1, 6));
         legal = ((rk >= 2) && (rk <= MAX_RANK)) ? 1 : 0;
         begin_job(dly, 0);
         pulse_job(rk, tr);
         wait_job();
         check_job(rk, tr, dly, (legal != 0) ? rk * rk : 0, (legal != 0) ? 0 : 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
